secuenciador_uf: RTL and testbench
==================================

SECUENCIADOR_UF -- requirements
Module: secuenciador_uf

Interface
REQ-001 The block SHALL have one clock and one asynchronous, active-low reset.
REQ-002 Port clk  input  1  clock; all state updates on rising edge.
REQ-003 Port rst_n  input  1  asynchronous active-low reset.
REQ-004 Port op_valid  input  1  operation request present.
REQ-005 Port op_ready  output  1  block accepts a request this cycle.
REQ-006 Port op_fs  input  4  function select to issue (functional-unit FS encoding).
REQ-007 Port op_rd / op_ra / op_rb  input  3 each  destination, A-source, B-source register indices.
REQ-008 Port ld_en / ld_addr / ld_data  input  1/3/16  direct register load.
REQ-009 Port dbg_addr  input  3; dbg_data  output  16  combinational register read-back.
REQ-010 Port fu_fs / fu_a / fu_b  output  4/16/16  operands driven to the functional unit.
REQ-011 Port fu_f / fu_v / fu_z / fu_n / fu_c  input  16/1/1/1/1  functional-unit result and flags.
REQ-012 Port done  output  1  one-cycle pulse when a result is written back.
REQ-013 Port flags  output  4  registered {V,Z,N,C} of the last completed operation.

Function
REQ-014 The block SHALL hold eight 16-bit registers R0..R7; R0 is writable (not hard-wired to zero).
REQ-015 The FSM SHALL have states IDLE, EXEC, WB.
REQ-016 op_ready SHALL be 1 only in IDLE; a request is accepted when op_valid and op_ready are both 1.
REQ-017 On acceptance the block SHALL register fu_fs=op_fs, fu_a=R[op_ra], fu_b=R[op_rb] and latch op_rd, then go to EXEC.
REQ-018 fu_fs/fu_a/fu_b SHALL stay stable from the EXEC cycle through the end of WB.
REQ-019 EXEC SHALL last exactly one cycle and then go to WB.
REQ-020 At the end of WB the block SHALL write fu_f into R[rd] and fu_v/fu_z/fu_n/fu_c into flags, pulse done for that one cycle, and return to IDLE.
REQ-021 Accept-to-done latency SHALL be 2 cycles; throughput SHALL be one operation per 3 cycles.
REQ-022 Operand reads SHALL sample register contents at the acceptance edge; ra=rb=rd is legal.
REQ-023 The clock period SHALL be at least 40 ns, so that the unit's combinational delay (up to about 27 ns) settles within EXEC+WB.
REQ-024 ld_en SHALL write ld_data into R[ld_addr] in any state.
REQ-025 If a load and a writeback target the same register on the same edge, the writeback SHALL win and the load SHALL be dropped.
REQ-026 A load to an operand register on the acceptance edge SHALL NOT affect the operands captured on that edge, which use the pre-load value.
REQ-027 flags SHALL be captured verbatim from the unit for every FS code, including shift codes 11xx.
REQ-028 op_valid in EXEC or WB SHALL be ignored, and no request SHALL be queued.

Reset
REQ-029 rst_n=0 SHALL immediately force the state to IDLE and clear R0..R7, fu_fs, fu_a, fu_b, flags and done to 0.
REQ-030 Reset asserted mid-operation SHALL abort it with no writeback and no done pulse.
REQ-031 After reset release, op_ready SHALL be 1 on the first cycle.

Structure
REQ-032 The shared package SHALL hold the state encoding (IDLE=2'b00, EXEC=2'b01, WB=2'b10) and named FS constants (FS_ADD=4'b0010, FS_SUB=4'b0101, FS_INC=4'b0001, FS_SHR=4'b1101, FS_XOR=4'b1010, etc.).
REQ-033 The register file SHALL be one sub-module, banco_registros: one write port with the priority of REQ-025 and three combinational read ports.
REQ-034 The bench SHALL instantiate the existing functional unit, connected to the fu_* ports.

Verification
REQ-035 Load R1=0x0005 and R2=0x0003, then issue FS=0101, rd=3, ra=1, rb=2 -> done 2 cycles after accept, R3=0x0002, flags C=1, V=0, Z=0, N=0.
REQ-036 Load R4=0x7FFF, then issue FS=0001, rd=4, ra=4 -> R4=0x8000, flags V=1, N=1, Z=0.
REQ-037 Load R5=0x00A5, then issue FS=1010, rd=6, ra=5, rb=5 -> R6=0x0000, Z=1.
REQ-038 Load R2=0x0003, then issue FS=1101, rd=7, rb=2 -> R7=0x0001; also issue FS=1110 -> R7=0x0006.
REQ-039 Hold op_valid=1 continuously with two queued ops -> op_ready is 0 during EXEC and WB, and the second op is accepted exactly 3 cycles after the first.
REQ-040 Assert rst_n=0 during EXEC, then assert ld_en at R[rd] coincident with a WB in a later run -> the first gives no done and all registers read 0; the second gives R[rd]=the ALU result, not ld_data.

Source files
------------

// File: rtl/secuenciador_uf_pkg.sv
// Shared types and constants for the functional-unit sequencer: FSM encoding,
// FS codes understood by the functional unit, and the flag bundle layout.
package secuenciador_uf_pkg;

  localparam int DATA_W   = 16;
  localparam int ADDR_W   = 3;
  localparam int NUM_REGS = 8;
  localparam int FS_W     = 4;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    WB   = 2'b10
  } state_t;

  // Function-select codes of the functional unit.
  localparam logic [FS_W-1:0] FS_TSFA = 4'b0000;
  localparam logic [FS_W-1:0] FS_INC  = 4'b0001;
  localparam logic [FS_W-1:0] FS_ADD  = 4'b0010;
  localparam logic [FS_W-1:0] FS_ADDC = 4'b0011;
  localparam logic [FS_W-1:0] FS_SUBB = 4'b0100;
  localparam logic [FS_W-1:0] FS_SUB  = 4'b0101;
  localparam logic [FS_W-1:0] FS_DEC  = 4'b0110;
  localparam logic [FS_W-1:0] FS_TSFX = 4'b0111;
  localparam logic [FS_W-1:0] FS_AND  = 4'b1000;
  localparam logic [FS_W-1:0] FS_OR   = 4'b1001;
  localparam logic [FS_W-1:0] FS_XOR  = 4'b1010;
  localparam logic [FS_W-1:0] FS_NOT  = 4'b1011;
  localparam logic [FS_W-1:0] FS_TSFB = 4'b1100;
  localparam logic [FS_W-1:0] FS_SHR  = 4'b1101;
  localparam logic [FS_W-1:0] FS_SHL  = 4'b1110;
  localparam logic [FS_W-1:0] FS_RSV  = 4'b1111;

  typedef struct packed {
    logic v;
    logic z;
    logic n;
    logic c;
  } flags_t;

  function automatic flags_t pack_flags(input logic v, input logic z,
                                        input logic n, input logic c);
    flags_t f;
    f.v = v;
    f.z = z;
    f.n = n;
    f.c = c;
    return f;
  endfunction

endpackage

// File: rtl/secuenciador_uf_banco_registros.sv
// Eight-entry 16-bit register file: two operand read ports, one debug read
// port, and a write stage where functional-unit writeback beats a direct load.
module banco_registros
  import secuenciador_uf_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              ld_en,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  input  logic [ADDR_W-1:0] rd_addr_dbg,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  output logic [DATA_W-1:0] rd_data_dbg
);

  logic [DATA_W-1:0] regs [NUM_REGS];

  // A load only lands where no writeback targets the same register this edge;
  // loads to other registers proceed in parallel with the writeback.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (wb_en && (wb_addr == ADDR_W'(i))) begin
          regs[i] <= wb_data;
        end else if (ld_en && (ld_addr == ADDR_W'(i))) begin
          regs[i] <= ld_data;
        end
      end
    end
  end

  assign rd_data_a   = regs[rd_addr_a];
  assign rd_data_b   = regs[rd_addr_b];
  assign rd_data_dbg = regs[rd_addr_dbg];

endmodule

// File: rtl/secuenciador_uf.sv
// Three-state sequencer that issues one register-to-register operation to an
// external functional unit and writes its result and flags back.
module secuenciador_uf
  import secuenciador_uf_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [FS_W-1:0]   op_fs,
  input  logic [ADDR_W-1:0] op_rd,
  input  logic [ADDR_W-1:0] op_ra,
  input  logic [ADDR_W-1:0] op_rb,
  input  logic              ld_en,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  output logic [FS_W-1:0]   fu_fs,
  output logic [DATA_W-1:0] fu_a,
  output logic [DATA_W-1:0] fu_b,
  input  logic [DATA_W-1:0] fu_f,
  input  logic              fu_v,
  input  logic              fu_z,
  input  logic              fu_n,
  input  logic              fu_c,
  output logic              done,
  output logic [3:0]        flags
);

  state_t            state;
  state_t            state_next;
  logic              accept;
  logic              wb_fire;
  logic [ADDR_W-1:0] rd_q;
  logic [DATA_W-1:0] opnd_a;
  logic [DATA_W-1:0] opnd_b;
  flags_t            flags_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Requests arriving outside IDLE are simply not acknowledged, so nothing queues.
  always_comb begin
    state_next = state;
    op_ready   = 1'b0;
    accept     = 1'b0;
    wb_fire    = 1'b0;
    case (state)
      IDLE: begin
        op_ready = 1'b1;
        if (op_valid) begin
          accept     = 1'b1;
          state_next = EXEC;
        end
      end
      EXEC: state_next = WB;
      WB: begin
        wb_fire    = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Operands come from the read ports before any same-edge load lands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fu_fs <= '0;
      fu_a  <= '0;
      fu_b  <= '0;
      rd_q  <= '0;
    end else if (accept) begin
      fu_fs <= op_fs;
      fu_a  <= opnd_a;
      fu_b  <= opnd_b;
      rd_q  <= op_rd;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done    <= 1'b0;
      flags_q <= '0;
    end else begin
      done <= wb_fire;
      if (wb_fire) begin
        flags_q <= pack_flags(fu_v, fu_z, fu_n, fu_c);
      end
    end
  end

  assign flags = flags_q;

  banco_registros u_banco (
    .clk         (clk),
    .rst_n       (rst_n),
    .wb_en       (wb_fire),
    .wb_addr     (rd_q),
    .wb_data     (fu_f),
    .ld_en       (ld_en),
    .ld_addr     (ld_addr),
    .ld_data     (ld_data),
    .rd_addr_a   (op_ra),
    .rd_addr_b   (op_rb),
    .rd_addr_dbg (dbg_addr),
    .rd_data_a   (opnd_a),
    .rd_data_b   (opnd_b),
    .rd_data_dbg (dbg_data)
  );

endmodule

// File: tb/tb_secuenciador_uf.sv
// Scoreboard bench for secuenciador_uf with a behavioural functional unit;
// stimulus pushes expectations, a negedge monitor pops and compares.
module tb_secuenciador_uf;
  import secuenciador_uf_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        op_valid;
  logic        op_ready;
  logic [3:0]  op_fs;
  logic [2:0]  op_rd, op_ra, op_rb;
  logic        ld_en;
  logic [2:0]  ld_addr;
  logic [15:0] ld_data;
  logic [2:0]  dbg_addr;
  logic [15:0] dbg_data;
  logic [3:0]  fu_fs;
  logic [15:0] fu_a, fu_b, fu_f;
  logic        fu_v, fu_z, fu_n, fu_c;
  logic        done;
  logic [3:0]  flags;

  typedef enum logic [1:0] {CK_REG, CK_READY, CK_DONE, CK_FLAGS} ck_kind_t;

  typedef struct {
    string       name;
    logic [2:0]  rd;
    logic [15:0] f;
    logic [3:0]  flg;
    int          cyc;
  } op_exp_t;

  typedef struct {
    ck_kind_t    kind;
    string       name;
    logic [2:0]  addr;
    logic [15:0] exp;
  } chk_t;

  op_exp_t op_q[$];
  chk_t    chk_q[$];
  int      cyc = 0;
  int      checks = 0;
  int      errors = 0;
  logic    stim_done = 1'b0;

  secuenciador_uf dut (
    .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op_ready(op_ready),
    .op_fs(op_fs), .op_rd(op_rd), .op_ra(op_ra), .op_rb(op_rb),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data),
    .fu_fs(fu_fs), .fu_a(fu_a), .fu_b(fu_b), .fu_f(fu_f),
    .fu_v(fu_v), .fu_z(fu_z), .fu_n(fu_n), .fu_c(fu_c),
    .done(done), .flags(flags)
  );

  always #20 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Functional unit: adder-based arithmetic, logic ops, single-bit shifts of B.
  logic [15:0] fu_bsel;
  logic        fu_cin;
  logic        fu_arith;
  logic [16:0] fu_sum;
  always_comb begin
    fu_bsel  = 16'h0000;
    fu_cin   = 1'b0;
    fu_arith = 1'b1;
    fu_f     = 16'h0000;
    fu_c     = 1'b0;
    fu_v     = 1'b0;
    case (fu_fs)
      4'b0000: ;
      4'b0001: fu_cin = 1'b1;
      4'b0010: fu_bsel = fu_b;
      4'b0011: begin fu_bsel = fu_b; fu_cin = 1'b1; end
      4'b0100: fu_bsel = ~fu_b;
      4'b0101: begin fu_bsel = ~fu_b; fu_cin = 1'b1; end
      4'b0110: fu_bsel = 16'hFFFF;
      4'b0111: ;
      default: fu_arith = 1'b0;
    endcase
    fu_sum = {1'b0, fu_a} + {1'b0, fu_bsel} + {16'd0, fu_cin};
    if (fu_arith) begin
      fu_f = fu_sum[15:0];
      fu_c = fu_sum[16];
      fu_v = (fu_a[15] == fu_bsel[15]) && (fu_f[15] != fu_a[15]);
    end else begin
      case (fu_fs)
        4'b1000: fu_f = fu_a & fu_b;
        4'b1001: fu_f = fu_a | fu_b;
        4'b1010: fu_f = fu_a ^ fu_b;
        4'b1011: fu_f = ~fu_a;
        4'b1100: fu_f = fu_b;
        4'b1101: begin fu_f = {1'b0, fu_b[15:1]}; fu_c = fu_b[0]; end
        4'b1110: begin fu_f = {fu_b[14:0], 1'b0}; fu_c = fu_b[15]; end
        default: fu_f = fu_b;
      endcase
    end
    fu_z = (fu_f == 16'h0000);
    fu_n = fu_f[15];
  end

  task automatic checkOutput(input string name, input logic [15:0] act,
                             input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic pushChk(input ck_kind_t kind, input string name,
                         input logic [2:0] addr, input logic [15:0] exp);
    chk_t k;
    k.kind = kind;
    k.name = name;
    k.addr = addr;
    k.exp  = exp;
    chk_q.push_back(k);
  endtask

  task automatic pushOp(input string name, input logic [2:0] rd,
                        input logic [15:0] f, input logic [3:0] flg, input int dcyc);
    op_exp_t e;
    e.name = name;
    e.rd   = rd;
    e.f    = f;
    e.flg  = flg;
    e.cyc  = dcyc;
    op_q.push_back(e);
  endtask

  task automatic waitCycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic loadReg(input logic [2:0] a, input logic [15:0] d);
    ld_en   = 1'b1;
    ld_addr = a;
    ld_data = d;
    waitCycles(1);
    ld_en = 1'b0;
  endtask

  // Issues one op from IDLE; returns #1 after the acceptance edge (EXEC).
  task automatic applyStimulus(input string name, input logic [3:0] fs,
                               input logic [2:0] rd, input logic [2:0] ra,
                               input logic [2:0] rb, input logic [15:0] exp_f,
                               input logic [3:0] exp_flg, input logic expect_done,
                               input logic with_ld, input logic [2:0] la,
                               input logic [15:0] ld_v);
    op_fs    = fs;
    op_rd    = rd;
    op_ra    = ra;
    op_rb    = rb;
    op_valid = 1'b1;
    if (with_ld) begin
      ld_en   = 1'b1;
      ld_addr = la;
      ld_data = ld_v;
    end
    pushChk(CK_READY, {name, "_ready"}, 3'd0, 16'd1);
    if (expect_done) pushOp(name, rd, exp_f, exp_flg, cyc + 3);
    waitCycles(1);
    op_valid = 1'b0;
    ld_en    = 1'b0;
  endtask

  initial begin : monitor
    op_exp_t e;
    chk_t    k;
    dbg_addr = 3'd0;
    forever begin
      @(negedge clk);
      if (done) begin
        if (op_q.size() == 0) begin
          checkOutput("done_without_op", {15'd0, done}, 16'd0);
        end else begin
          e = op_q.pop_front();
          checkOutput({e.name, "_done_cycle"}, 16'(cyc), 16'(e.cyc));
          checkOutput({e.name, "_flags"}, {12'd0, flags}, {12'd0, e.flg});
          dbg_addr = e.rd;
          #1;
          checkOutput({e.name, "_result"}, dbg_data, e.f);
        end
      end
      while (chk_q.size() > 0) begin
        k = chk_q.pop_front();
        case (k.kind)
          CK_REG: begin
            dbg_addr = k.addr;
            #1;
            checkOutput(k.name, dbg_data, k.exp);
          end
          CK_READY: checkOutput(k.name, {15'd0, op_ready}, k.exp);
          CK_DONE:  checkOutput(k.name, {15'd0, done}, k.exp);
          default:  checkOutput(k.name, {12'd0, flags}, k.exp);
        endcase
      end
      if (stim_done) begin
        checkOutput("ops_outstanding", 16'(op_q.size()), 16'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] timeout");
  end

  initial begin : stimulus
    rst_n    = 1'b0;
    op_valid = 1'b0;
    op_fs    = 4'd0;
    op_rd    = 3'd0;
    op_ra    = 3'd0;
    op_rb    = 3'd0;
    ld_en    = 1'b0;
    ld_addr  = 3'd0;
    ld_data  = 16'd0;
    waitCycles(2);
    for (int i = 0; i < 8; i++) pushChk(CK_REG, $sformatf("reset_r%0d", i), 3'(i), 16'd0);
    pushChk(CK_FLAGS, "reset_flags", 3'd0, 16'd0);
    pushChk(CK_DONE, "reset_done", 3'd0, 16'd0);
    waitCycles(1);
    rst_n = 1'b1;
    pushChk(CK_READY, "ready_after_reset", 3'd0, 16'd1);

    loadReg(3'd1, 16'h0005);
    loadReg(3'd2, 16'h0003);
    pushChk(CK_REG, "load_r1", 3'd1, 16'h0005);
    applyStimulus("sub", FS_SUB, 3'd3, 3'd1, 3'd2, 16'h0002, 4'b0001, 1'b1, 1'b0, 3'd0, 16'd0);
    waitCycles(3);

    loadReg(3'd4, 16'h7FFF);
    applyStimulus("inc_ovf", FS_INC, 3'd4, 3'd4, 3'd0, 16'h8000, 4'b1010, 1'b1, 1'b0, 3'd0, 16'd0);
    waitCycles(3);

    loadReg(3'd5, 16'h00A5);
    applyStimulus("xor_zero", FS_XOR, 3'd6, 3'd5, 3'd5, 16'h0000, 4'b0100, 1'b1, 1'b0, 3'd0, 16'd0);
    waitCycles(3);

    applyStimulus("shr", FS_SHR, 3'd7, 3'd0, 3'd2, 16'h0001, 4'b0001, 1'b1, 1'b0, 3'd0, 16'd0);
    waitCycles(2);
    applyStimulus("shl", FS_SHL, 3'd7, 3'd0, 3'd2, 16'h0006, 4'b0000, 1'b1, 1'b0, 3'd0, 16'd0);
    waitCycles(3);

    loadReg(3'd0, 16'h1234);
    applyStimulus("add_r0_self", FS_ADD, 3'd0, 3'd0, 3'd0, 16'h2468, 4'b0000, 1'b1, 1'b0, 3'd0, 16'd0);
    waitCycles(3);

    // Load into R1 on the acceptance edge: operand must be the old 0x0005.
    applyStimulus("add_ld_same_edge", FS_ADD, 3'd1, 3'd1, 3'd2, 16'h0008, 4'b0000, 1'b1, 1'b1, 3'd1, 16'h0100);
    pushChk(CK_REG, "ld_on_accept_lands", 3'd1, 16'h0100);
    waitCycles(3);

    // Back-to-back with op_valid held: second op reads the first op's result.
    op_fs = FS_ADD; op_rd = 3'd3; op_ra = 3'd1; op_rb = 3'd2; op_valid = 1'b1;
    pushOp("b2b_add", 3'd3, 16'h000B, 4'b0000, cyc + 3);
    pushChk(CK_READY, "b2b_ready_idle", 3'd0, 16'd1);
    waitCycles(1);
    op_fs = FS_SUB; op_rd = 3'd4; op_ra = 3'd3; op_rb = 3'd2;
    pushOp("b2b_sub", 3'd4, 16'h0008, 4'b0001, cyc + 5);
    pushChk(CK_READY, "b2b_ready_exec", 3'd0, 16'd0);
    waitCycles(1);
    pushChk(CK_READY, "b2b_ready_wb", 3'd0, 16'd0);
    waitCycles(1);
    pushChk(CK_READY, "b2b_ready_idle2", 3'd0, 16'd1);
    waitCycles(1);
    op_valid = 1'b0;
    pushChk(CK_READY, "b2b_ready_exec2", 3'd0, 16'd0);
    waitCycles(3);

    // Load to R5 coincident with the writeback edge: writeback must win.
    applyStimulus("wb_vs_ld", FS_OR, 3'd5, 3'd1, 3'd2, 16'h000B, 4'b0000, 1'b1, 1'b0, 3'd0, 16'd0);
    waitCycles(1);
    ld_en = 1'b1; ld_addr = 3'd5; ld_data = 16'hDEAD;
    waitCycles(1);
    ld_en = 1'b0;
    pushChk(CK_REG, "wb_vs_ld_r5", 3'd5, 16'h000B);
    waitCycles(2);

    // Reset during EXEC aborts the op: no done, everything cleared.
    applyStimulus("abort", FS_ADD, 3'd6, 3'd1, 3'd2, 16'h0000, 4'b0000, 1'b0, 1'b0, 3'd0, 16'd0);
    rst_n = 1'b0;
    pushChk(CK_DONE, "abort_done", 3'd0, 16'd0);
    waitCycles(2);
    rst_n = 1'b1;
    pushChk(CK_READY, "ready_after_abort", 3'd0, 16'd1);
    for (int i = 0; i < 8; i++) pushChk(CK_REG, $sformatf("abort_r%0d", i), 3'(i), 16'd0);
    pushChk(CK_FLAGS, "abort_flags", 3'd0, 16'd0);
    waitCycles(4);

    applyStimulus("dec_neg", FS_DEC, 3'd2, 3'd2, 3'd0, 16'hFFFF, 4'b0010, 1'b1, 1'b0, 3'd0, 16'd0);
    waitCycles(4);
    stim_done = 1'b1;
  end

endmodule
